reg_file_ser_master: RTL



---
 rtl/reg_file_ser_master_if.sv | 29 ++
 rtl/reg_file_ser_master.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_ser_master_if.sv
// rtl/reg_file_ser_master_if.sv - request/response and reg_file serial bus bundle
interface reg_file_ser_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_wr;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  busy;
    logic                  wr_en;
    logic                  rd_en;
    logic                  din;
    logic                  dout;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, dout,
        output req_ready, rsp_valid, rsp_wr, rsp_rdata, busy, wr_en, rd_en, din
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, dout,
        input  req_ready, rsp_valid, rsp_wr, rsp_rdata, busy, wr_en, rd_en, din
    );
endinterface

// File: rtl/reg_file_ser_master.sv
// rtl/reg_file_ser_master.sv - parallel request to reg_file one-wire serial bridge
module reg_file_ser_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_file_ser_master_if.master bus
);
    localparam int A  = ADDR_WIDTH;
    localparam int D  = DATA_WIDTH;
    localparam int FW = A + D;
    localparam int CW = $clog2(A + D + 2);
    localparam logic [CW-1:0] LAST_ADDR = CW'(A);
    localparam logic [CW-1:0] LAST_DATA = CW'(A + D);
    localparam logic [CW-1:0] OVERLAP   = CW'(A + D - 1);

    typedef enum logic [2:0] {IDLE, START, ADDR, WDATA, GAP, RDATA} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cur_wr_q, cur_wr_d;
    logic [FW-1:0] tx_q, tx_d;
    logic [D-1:0]  rx_q, rx_d;
    logic          rsp_due_q, rsp_due_d;
    logic          pend_valid_q, pend_valid_d;
    logic          pend_wr_q, pend_wr_d;
    logic [A-1:0]  pend_addr_q, pend_addr_d;
    logic [D-1:0]  pend_wdata_q, pend_wdata_d;

    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_wr_q, rsp_wr_d;
    logic [D-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic          busy_q, busy_d;
    logic          wr_en_q, wr_en_d;
    logic          rd_en_q, rd_en_d;
    logic          din_q, din_d;

    logic          accept, req_avail, start, shift_out;
    logic          src_wr;
    logic [A-1:0]  src_addr;
    logic [D-1:0]  src_payload;

    // The pending entry always has priority; a fresh request is only used directly when the slot is empty.
    always_comb begin
        accept      = bus.req_valid && req_ready_q;
        req_avail   = pend_valid_q || accept;
        src_wr      = pend_valid_q ? pend_wr_q   : bus.req_wr;
        src_addr    = pend_valid_q ? pend_addr_q : bus.req_addr;
        src_payload = '0;
        if (src_wr) begin
            src_payload = pend_valid_q ? pend_wdata_q : bus.req_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_wr_d    = cur_wr_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rsp_due_d   = 1'b0;
        start       = 1'b0;
        shift_out   = 1'b0;
        rsp_valid_d = rsp_due_q;
        rsp_wr_d    = rsp_due_q;
        rsp_rdata_d = '0;

        case (state_q)
            IDLE: start = req_avail;
            START: begin
                state_d   = ADDR;
                cnt_d     = cnt_q + CW'(1);
                shift_out = 1'b1;
            end
            ADDR: begin
                cnt_d     = cnt_q + CW'(1);
                shift_out = cur_wr_q || (cnt_q != LAST_ADDR);
                if (cnt_q == LAST_ADDR) begin
                    state_d = cur_wr_q ? WDATA : GAP;
                end
            end
            WDATA: begin
                // A waiting request launches under the last data bit; the response follows one cycle later.
                if (cnt_q == OVERLAP && req_avail) begin
                    start     = 1'b1;
                    rsp_due_d = 1'b1;
                    shift_out = 1'b1;
                end else if (cnt_q == LAST_DATA) begin
                    rsp_valid_d = 1'b1;
                    rsp_wr_d    = 1'b1;
                    start       = req_avail;
                    state_d     = IDLE;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    shift_out = 1'b1;
                end
            end
            GAP, RDATA: begin
                rx_d = D'({rx_q, bus.dout});
                if (cnt_q == LAST_DATA) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = D'({rx_q, bus.dout});
                    start       = req_avail;
                    state_d     = IDLE;
                end else begin
                    state_d = RDATA;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d  = START;
            cnt_d    = '0;
            cur_wr_d = src_wr;
        end

        din_d = shift_out ? tx_q[FW-1] : 1'b0;
        if (start) begin
            tx_d = {src_addr, src_payload};
        end else if (shift_out) begin
            tx_d = tx_q << 1;
        end
        wr_en_d = start && src_wr;
        rd_en_d = start && !src_wr;

        pend_wr_d    = pend_wr_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        if (pend_valid_q) begin
            pend_valid_d = !start;
        end else begin
            pend_valid_d = accept && !start;
            if (accept && !start) begin
                pend_wr_d    = bus.req_wr;
                pend_addr_d  = bus.req_addr;
                pend_wdata_d = bus.req_wdata;
            end
        end

        req_ready_d = !pend_valid_d;
        busy_d      = (state_d != IDLE) || pend_valid_d || rsp_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cur_wr_q     <= 1'b0;
            tx_q         <= '0;
            rx_q         <= '0;
            rsp_due_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_wr_q     <= 1'b0;
            rsp_rdata_q  <= '0;
            busy_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            din_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_wr_q     <= cur_wr_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            rsp_due_q    <= rsp_due_d;
            pend_valid_q <= pend_valid_d;
            pend_wr_q    <= pend_wr_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_wr_q     <= rsp_wr_d;
            rsp_rdata_q  <= rsp_rdata_d;
            busy_q       <= busy_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            din_q        <= din_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_wr    = rsp_wr_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = busy_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.din       = din_q;
endmodule
